cae_window_feeder: RTL and testbench
====================================

# cae_window_feeder

Streaming front-end for the CAE core; drives the core's `en`, `layer`, `data_in`, `weight_in` and `bias_in` inputs.
- Accepts a weight/bias stream and a raster pixel stream through valid/ready handshakes.
- Assembles 3-row × `INPUT_SIZE` windows with vertical stride 1, or single rows in FC mode.
- Pulses `en` once per complete window.

## Interface
- `DATA_WIDTH`, default `` `DATA_WIDTH ``: sample and weight width.
- `BIAS_WIDTH`, default `` `BIAS_WIDTH ``: bias width.
- `INPUT_SIZE`, default `` `INPUT_SIZE ``: samples per row, and weights per kernel.
- `IMG_ROWS`, default 8: rows per frame (≥1).
- `clk_i` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `start` in 1: begins a frame; sampled only in IDLE.
- `layer_sel` in `cae_layer_t`: CONV=0 / FC=1; latched on `start`.
- `wgt_valid` in 1, `wgt_ready` out 1, `wgt_data` in `DATA_WIDTH`, `bias_data` in `BIAS_WIDTH`: weight/bias stream.
- `pix_valid` in 1, `pix_ready` out 1, `pix_data` in `DATA_WIDTH`: pixel stream, row-major.
- `en` out 1: one-cycle window strobe to the core.
- `layer` out `cae_layer_t`: latched mode.
- `data_in` out [2:0][`INPUT_SIZE`-1:0] × `DATA_WIDTH`: window; [0] oldest row, [2] newest row.
- `weight_in` out [`INPUT_SIZE`-1:0] × `DATA_WIDTH`; `bias_in` out `BIAS_WIDTH`.
- `busy` out 1: high whenever not in IDLE.
- `frame_done` out 1: one-cycle pulse at end of frame.

## Operation
- States: IDLE, LOAD_W, LOAD_B, FILL, ISSUE, DONE.
- IDLE: `start`=1 → latch `layer_sel` into `layer`; clear the column, row and fill counters; go to LOAD_W.
- LOAD_W:
  - `wgt_ready`=1; each handshake writes `weight_in[widx]`, with `widx` counting 0..`INPUT_SIZE`-1.
  - After the beat at `widx`=`INPUT_SIZE`-1 → LOAD_B.
- LOAD_B: `wgt_ready`=1; a handshake latches `bias_data` into `bias_in` → FILL.
- FILL:
  - `pix_ready`=1; each handshake writes `row_buf[col]`, with `col` counting 0..`INPUT_SIZE`-1.
  - On the last column the row is committed and `row_cnt`++.
- Commit in CONV mode:
  - `data_in[0]`←`data_in[1]`, `data_in[1]`←`data_in[2]`, `data_in[2]`←row.
  - `fill` increments and saturates at 3.
  - If `fill` reaches 3 → ISSUE; else stay in FILL. If that was the last row (`row_cnt`=`IMG_ROWS`) and no window is due → DONE.
- Commit in FC mode: `data_in[0]`←row, `data_in[1]`=`data_in[2]`=0 → ISSUE.
- ISSUE:
  - `en`=1 for exactly one cycle; `pix_ready`=0.
  - Next state is DONE if `row_cnt`=`IMG_ROWS`, else FILL.
- DONE: `frame_done`=1 for one cycle → IDLE. Weights and bias are retained; `data_in` is retained until the next `start`.
- Windows per frame: CONV issues max(0, `IMG_ROWS`-2); FC issues `IMG_ROWS`.
- Handshakes are ignored in states that do not own them, since the corresponding ready is 0.
- `start` outside IDLE is ignored.

## Timing
- Reset (`rst`=0, asynchronous): state IDLE; all counters cleared. Every output is 0: `en`, `busy`, `frame_done`, `wgt_ready`, `pix_ready`, `data_in`, `weight_in`, `bias_in`, and `layer`=CONV.
- Reset asserted mid-frame aborts the frame with no `frame_done`.
- `start` at edge t → `busy` and `wgt_ready` high from t+1.
- Last pixel of a row handshaken at edge t:
  - `data_in` is updated at edge t; `en` is high during cycle t..t+1.
  - `pix_ready` returns high at t+1 if the frame is not done.
- `data_in`, `weight_in` and `bias_in` are stable throughout the `en` cycle and until the next row commit.
- All outputs are registered; ready signals depend only on state.

## Structure
- Shared package `cae_pkg`:
  - `cae_layer_t` (CONV=0, FC=1).
  - `feeder_state_t`.
  - Widths taken from `parameters.sv` macros.
- Sub-module `cae_row_window`: the `row_buf` write port plus the 3-row shift register, with inputs commit/mode and outputs `data_in`.
- The FSM and counters stay in `cae_window_feeder`.

## Test plan
All scenarios use `INPUT_SIZE`=4, `IMG_ROWS`=5, and pixel value = 10·row+col.
1. Reset mid-LOAD_W → all outputs 0, IDLE. A new `start` then reloads weights 1,2,3,4 and bias 7 → `weight_in`={4,3,2,1} (index 3 down to 0), `bias_in`=7.
2. CONV frame, continuous valid → exactly 3 `en` pulses.
   - First pulse: `data_in[0]`={3,2,1,0}, `data_in[2]`={23,22,21,20}.
   - Last pulse: `data_in[2]`={43,42,41,40}.
   - `frame_done` one cycle after the third `en`.
3. FC frame → 5 `en` pulses; `data_in[0]` = each row in turn; `data_in[1]` and `data_in[2]` = 0.
4. Random `pix_valid`/`wgt_valid` gaps → window contents identical to scenario 2; `pix_ready`=0 on every `en` cycle; no pixel lost or duplicated.
5. `IMG_ROWS`=2 in CONV → no `en`; `frame_done` pulses after the 8th pixel.
6. `start` pulsed during FILL and `pix_valid` held high in IDLE → no state change, no pixel accepted.

Source files
------------

// File: rtl/cae_pkg.sv
// Shared types and width defaults for the CAE streaming front-end.
`ifndef DATA_WIDTH
`define DATA_WIDTH 8
`endif
`ifndef BIAS_WIDTH
`define BIAS_WIDTH 16
`endif
`ifndef INPUT_SIZE
`define INPUT_SIZE 4
`endif

package cae_pkg;

    localparam int unsigned DataWidth = `DATA_WIDTH;
    localparam int unsigned BiasWidth = `BIAS_WIDTH;
    localparam int unsigned InputSize = `INPUT_SIZE;

    typedef enum logic {
        CONV = 1'b0,
        FC   = 1'b1
    } cae_layer_t;

    typedef enum logic [2:0] {
        StIdle,
        StLoadW,
        StLoadB,
        StFill,
        StIssue,
        StDone
    } feeder_state_t;

endpackage

// File: rtl/cae_row_window.sv
// Row assembly buffer plus the three-row window shift register.
module cae_row_window
    import cae_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = `DATA_WIDTH,
    parameter int unsigned INPUT_SIZE = `INPUT_SIZE,
    parameter int unsigned COL_W      = 2
) (
    input  logic                                         clk_i,
    input  logic                                         rst,
    input  logic                                         clear,
    input  logic                                         wr_en,
    input  logic [COL_W-1:0]                             wr_col,
    input  logic [DATA_WIDTH-1:0]                        wr_data,
    input  logic                                         commit,
    input  cae_layer_t                                   mode,
    output logic [2:0][INPUT_SIZE-1:0][DATA_WIDTH-1:0]   data_in
);

    logic [INPUT_SIZE-1:0][DATA_WIDTH-1:0] row_buf_q;
    logic [INPUT_SIZE-1:0][DATA_WIDTH-1:0] row_next;

    // The committing beat is folded in here so the row lands in the same edge.
    always_comb begin
        row_next = row_buf_q;
        if (wr_en) begin
            row_next[wr_col] = wr_data;
        end
    end

    always_ff @(posedge clk_i or negedge rst) begin
        if (!rst) begin
            row_buf_q <= '0;
            data_in   <= '0;
        end else if (clear) begin
            row_buf_q <= '0;
            data_in   <= '0;
        end else begin
            if (wr_en) begin
                row_buf_q <= row_next;
            end
            if (commit) begin
                if (mode == FC) begin
                    data_in[0] <= row_next;
                    data_in[1] <= '0;
                    data_in[2] <= '0;
                end else begin
                    data_in[0] <= data_in[1];
                    data_in[1] <= data_in[2];
                    data_in[2] <= row_next;
                end
            end
        end
    end

endmodule

// File: rtl/cae_window_feeder.sv
// Streaming front-end: loads kernel weights/bias, then assembles row windows for the CAE core.
module cae_window_feeder
    import cae_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = `DATA_WIDTH,
    parameter int unsigned BIAS_WIDTH = `BIAS_WIDTH,
    parameter int unsigned INPUT_SIZE = `INPUT_SIZE,
    parameter int unsigned IMG_ROWS   = 8
) (
    input  logic                                         clk_i,
    input  logic                                         rst,
    input  logic                                         start,
    input  cae_layer_t                                   layer_sel,
    input  logic                                         wgt_valid,
    output logic                                         wgt_ready,
    input  logic [DATA_WIDTH-1:0]                        wgt_data,
    input  logic [BIAS_WIDTH-1:0]                        bias_data,
    input  logic                                         pix_valid,
    output logic                                         pix_ready,
    input  logic [DATA_WIDTH-1:0]                        pix_data,
    output logic                                         en,
    output cae_layer_t                                   layer,
    output logic [2:0][INPUT_SIZE-1:0][DATA_WIDTH-1:0]   data_in,
    output logic [INPUT_SIZE-1:0][DATA_WIDTH-1:0]        weight_in,
    output logic [BIAS_WIDTH-1:0]                        bias_in,
    output logic                                         busy,
    output logic                                         frame_done
);

    localparam int unsigned ColW = (INPUT_SIZE > 1) ? $clog2(INPUT_SIZE) : 1;
    localparam int unsigned RowW = $clog2(IMG_ROWS + 1);
    localparam logic [ColW-1:0] LastCol = ColW'(INPUT_SIZE - 1);
    localparam logic [RowW-1:0] LastRow = RowW'(IMG_ROWS);

    feeder_state_t   state_q, state_d;
    logic [ColW-1:0] widx_q, col_q;
    logic [RowW-1:0] row_cnt_q;
    logic [1:0]      fill_q, fill_inc;
    logic            wgt_fire, pix_fire, row_done, last_row, frame_start;

    assign wgt_fire    = wgt_valid && wgt_ready;
    assign pix_fire    = pix_valid && pix_ready;
    assign row_done    = pix_fire && (col_q == LastCol);
    assign last_row    = (row_cnt_q + RowW'(1)) == LastRow;
    assign frame_start = (state_q == StIdle) && start;
    assign fill_inc    = (fill_q == 2'd3) ? 2'd3 : fill_q + 2'd1;

    always_ff @(posedge clk_i or negedge rst) begin
        if (!rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (start) state_d = StLoadW;
            StLoadW: if (wgt_fire && widx_q == LastCol) state_d = StLoadB;
            StLoadB: if (wgt_fire) state_d = StFill;
            StFill: begin
                if (row_done) begin
                    // CONV needs two rows already held before the commit completes a window.
                    if (layer == FC || fill_q >= 2'd2) begin
                        state_d = StIssue;
                    end else if (last_row) begin
                        state_d = StDone;
                    end
                end
            end
            StIssue: state_d = (row_cnt_q == LastRow) ? StDone : StFill;
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        en         = (state_q == StIssue);
        busy       = (state_q != StIdle);
        frame_done = (state_q == StDone);
        wgt_ready  = (state_q == StLoadW) || (state_q == StLoadB);
        pix_ready  = (state_q == StFill);
    end

    always_ff @(posedge clk_i or negedge rst) begin
        if (!rst) begin
            widx_q    <= '0;
            col_q     <= '0;
            row_cnt_q <= '0;
            fill_q    <= '0;
            layer     <= CONV;
            weight_in <= '0;
            bias_in   <= '0;
        end else begin
            if (frame_start) begin
                widx_q    <= '0;
                col_q     <= '0;
                row_cnt_q <= '0;
                fill_q    <= '0;
                layer     <= layer_sel;
            end
            if (wgt_fire && state_q == StLoadW) begin
                weight_in[widx_q] <= wgt_data;
                widx_q            <= (widx_q == LastCol) ? '0 : widx_q + ColW'(1);
            end
            if (wgt_fire && state_q == StLoadB) begin
                bias_in <= bias_data;
            end
            if (pix_fire) begin
                col_q <= (col_q == LastCol) ? '0 : col_q + ColW'(1);
            end
            if (row_done) begin
                row_cnt_q <= row_cnt_q + RowW'(1);
                if (layer == CONV) begin
                    fill_q <= fill_inc;
                end
            end
        end
    end

    cae_row_window #(
        .DATA_WIDTH (DATA_WIDTH),
        .INPUT_SIZE (INPUT_SIZE),
        .COL_W      (ColW)
    ) u_row_window (
        .clk_i   (clk_i),
        .rst     (rst),
        .clear   (frame_start),
        .wr_en   (pix_fire),
        .wr_col  (col_q),
        .wr_data (pix_data),
        .commit  (row_done),
        .mode    (layer),
        .data_in (data_in)
    );

endmodule

// File: tb/tb_cae_window_feeder.sv
// Self-checking bench: randomized handshake gaps and data against a row-list window model.
module tb_cae_window_feeder;
    import cae_pkg::*;

    localparam int DW = 8;
    localparam int BW = 16;
    localparam int IS = 4;
    localparam int R1 = 5;
    localparam int R2 = 2;

    typedef logic [2:0][IS-1:0][DW-1:0] win_t;
    typedef logic [IS-1:0][DW-1:0]      row_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic           rst, start, start2, wgt_valid, pix_valid;
    cae_layer_t     layer_sel;
    logic [DW-1:0]  wgt_data, pix_data;
    logic [BW-1:0]  bias_data;

    logic           wgt_ready_a, pix_ready_a, en_a, busy_a, done_a;
    logic           wgt_ready_b, pix_ready_b, en_b, busy_b, done_b;
    cae_layer_t     layer_a, layer_b;
    win_t           data_a, data_b;
    row_t           w_a, w_b;
    logic [BW-1:0]  b_a, b_b;

    cae_window_feeder #(
        .DATA_WIDTH (DW), .BIAS_WIDTH (BW), .INPUT_SIZE (IS), .IMG_ROWS (R1)
    ) dut_a (
        .clk_i (clk), .rst (rst), .start (start), .layer_sel (layer_sel),
        .wgt_valid (wgt_valid), .wgt_ready (wgt_ready_a), .wgt_data (wgt_data),
        .bias_data (bias_data), .pix_valid (pix_valid), .pix_ready (pix_ready_a),
        .pix_data (pix_data), .en (en_a), .layer (layer_a), .data_in (data_a),
        .weight_in (w_a), .bias_in (b_a), .busy (busy_a), .frame_done (done_a)
    );

    cae_window_feeder #(
        .DATA_WIDTH (DW), .BIAS_WIDTH (BW), .INPUT_SIZE (IS), .IMG_ROWS (R2)
    ) dut_b (
        .clk_i (clk), .rst (rst), .start (start2), .layer_sel (layer_sel),
        .wgt_valid (wgt_valid), .wgt_ready (wgt_ready_b), .wgt_data (wgt_data),
        .bias_data (bias_data), .pix_valid (pix_valid), .pix_ready (pix_ready_b),
        .pix_data (pix_data), .en (en_b), .layer (layer_b), .data_in (data_b),
        .weight_in (w_b), .bias_in (b_b), .busy (busy_b), .frame_done (done_b)
    );

    int npass = 0, nfail = 0, ntotal = 0;
    bit sel = 1'b0;
    int en_b_cnt = 0;
    win_t win_q[$];
    logic [DW-1:0] acc_q[$];
    row_t exp_w;
    logic [BW-1:0] exp_b;
    logic [DW-1:0] pix[R1][IS];
    logic wgt_ready_cur, pix_ready_cur;

    assign wgt_ready_cur = sel ? wgt_ready_b : wgt_ready_a;
    assign pix_ready_cur = sel ? pix_ready_b : pix_ready_a;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        ntotal++;
        assert (obs === exp) npass++;
        else begin
            nfail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Capture windows and accepted pixels away from the active edge.
    always @(negedge clk) begin
        if (en_a) begin
            win_q.push_back(data_a);
            check("pix_ready_on_en", pix_ready_a, 1'b0);
            check("weight_in_on_en", w_a, exp_w);
            check("bias_in_on_en", b_a, exp_b);
        end
        if (en_b) en_b_cnt++;
        if (pix_valid && (pix_ready_a || pix_ready_b)) acc_q.push_back(pix_data);
    end

    task automatic push_wgt(input logic [DW-1:0] d, input logic [BW-1:0] b, input bit gaps);
        int guard = 0;
        if (gaps) while ($urandom_range(0, 2) == 0) begin wgt_valid = 0; @(posedge clk); #1; end
        wgt_valid = 1'b1; wgt_data = d; bias_data = b;
        @(negedge clk);
        while (!wgt_ready_cur && guard < 100) begin @(negedge clk); guard++; end
        check("wgt_handshake_bound", guard < 100, 1'b1);
        @(posedge clk); #1;
        wgt_valid = 1'b0;
    endtask

    task automatic push_pix(input logic [DW-1:0] d, input bit gaps);
        int guard = 0;
        if (gaps) while ($urandom_range(0, 2) == 0) begin pix_valid = 0; @(posedge clk); #1; end
        pix_valid = 1'b1; pix_data = d;
        @(negedge clk);
        while (!pix_ready_cur && guard < 100) begin @(negedge clk); guard++; end
        check("pix_handshake_bound", guard < 100, 1'b1);
        @(posedge clk); #1;
        pix_valid = 1'b0;
    endtask

    task automatic run_frame(input cae_layer_t mode, input bit gaps, input bit rnd,
                             input bit on_b, input bit fixed_w, input bit poke);
        int rows = on_b ? R2 : R1;
        int nwin, lat;
        win_t e;
        for (int r = 0; r < rows; r++)
            for (int c = 0; c < IS; c++)
                pix[r][c] = rnd ? DW'($urandom) : DW'(10 * r + c);
        for (int i = 0; i < IS; i++) exp_w[i] = fixed_w ? DW'(i + 1) : DW'($urandom);
        exp_b = fixed_w ? BW'(7) : BW'($urandom);
        acc_q.delete(); win_q.delete(); en_b_cnt = 0;
        sel = on_b; layer_sel = mode;
        if (on_b) start2 = 1'b1; else start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; start2 = 1'b0;
        check("busy_after_start", on_b ? busy_b : busy_a, 1'b1);
        check("wgt_ready_after_start", wgt_ready_cur, 1'b1);
        for (int i = 0; i < IS; i++) push_wgt(exp_w[i], '0, gaps);
        push_wgt('0, exp_b, gaps);
        check("weight_in_loaded", on_b ? w_b : w_a, exp_w);
        check("bias_in_loaded", on_b ? b_b : b_a, exp_b);
        for (int r = 0; r < rows; r++)
            for (int c = 0; c < IS; c++) begin
                push_pix(pix[r][c], gaps);
                if (poke && r == 1 && c == 1) begin
                    layer_sel = (mode == FC) ? CONV : FC;
                    start = 1'b1; @(posedge clk); #1; start = 1'b0;
                    check("poke_busy", busy_a, 1'b1);
                    check("poke_layer", layer_a, mode);
                    check("poke_pix_ready", pix_ready_a, 1'b1);
                end
            end
        nwin = (mode == FC) ? rows : ((rows > 2) ? rows - 2 : 0);
        lat = 0;
        @(negedge clk);
        while (!(on_b ? done_b : done_a) && lat < 50) begin @(negedge clk); lat++; end
        check("frame_done_latency", lat, (nwin > 0) ? 1 : 0);
        @(posedge clk); #1;
        check("idle_after_done", on_b ? busy_b : busy_a, 1'b0);
        check("accepted_count", acc_q.size(), rows * IS);
        for (int r = 0; r < rows; r++)
            for (int c = 0; c < IS; c++)
                if (r * IS + c < acc_q.size())
                    check($sformatf("pixel_r%0d_c%0d", r, c), acc_q[r * IS + c], pix[r][c]);
        if (on_b) begin
            check("en_count_b", en_b_cnt, 0);
        end else begin
            check("window_count", win_q.size(), nwin);
            for (int k = 0; k < nwin; k++) begin
                e = '0;
                for (int c = 0; c < IS; c++) begin
                    if (mode == FC) e[0][c] = pix[k][c];
                    else for (int j = 0; j < 3; j++) e[j][c] = pix[k + j][c];
                end
                if (k < win_q.size()) check($sformatf("window_%0d", k), win_q[k], e);
            end
        end
    endtask

    initial begin
        rst = 1'b0; start = 1'b0; start2 = 1'b0; layer_sel = CONV;
        wgt_valid = 1'b0; wgt_data = '0; bias_data = '0; pix_valid = 1'b0; pix_data = '0;
        @(negedge clk);
        check("rst_busy", busy_a, 1'b0);
        check("rst_ready", {wgt_ready_a, pix_ready_a, en_a, done_a}, 4'b0);
        check("rst_data_in", data_a, '0);
        @(posedge clk); #1;
        rst = 1'b1;

        // FC frame leaves nonzero window and weights behind for the reset check.
        run_frame(FC, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);

        sel = 1'b0; layer_sel = FC; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        push_wgt(8'h5a, '0, 1'b0);
        push_wgt(8'ha5, '0, 1'b0);
        rst = 1'b0;
        #1;
        check("midrst_ctrl", {en_a, busy_a, done_a, wgt_ready_a, pix_ready_a}, 5'b0);
        check("midrst_data_in", data_a, '0);
        check("midrst_weight_in", w_a, '0);
        check("midrst_bias_in", b_a, '0);
        check("midrst_layer", layer_a, CONV);
        @(posedge clk); #1;
        check("midrst_no_done", done_a, 1'b0);
        rst = 1'b1;

        run_frame(CONV, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        run_frame(FC,   1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        run_frame(CONV, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        run_frame(CONV, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        run_frame(FC,   1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
        run_frame(CONV, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);

        // Valid held high while both feeders sit idle must not be consumed.
        acc_q.delete();
        pix_valid = 1'b1; pix_data = 8'd55;
        repeat (6) @(posedge clk);
        #1;
        check("idle_pix_ready", {pix_ready_a, pix_ready_b}, 2'b0);
        check("idle_busy", {busy_a, busy_b}, 2'b0);
        check("idle_no_accept", acc_q.size(), 0);
        pix_valid = 1'b0;

        $display("%0d/%0d checks passed", npass, ntotal);
        $finish;
    end

endmodule
